// File: rtl/genie_mem_pkg.sv
// genie_mem_pkg: shared definitions for the genie external-memory bridge.
//   - FSM state encoding for the bridge controller
//   - default address/data widths
//   - width of the read-latency counter (READ_LAT is limited to 1..15)
package genie_mem_pkg;

  localparam int unsigned ADDR_W_DEF = 26;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned CNT_W      = 4;

  typedef enum logic [2:0] {
    StIdle,
    StWrIssue,
    StWrAck,
    StRdIssue,
    StRdWait,
    StRdResp
  } state_e;

endpackage

// File: rtl/genie_mem_prefetch_buf.sv
// genie_mem_prefetch_buf: single-entry sequential-read prefetch buffer.
// Holds one speculatively read word (pf_addr/pf_data/pf_valid) plus the state of an in-flight
// speculative read (pending, remaining latency, stale), and owns the hit/invalidate compares.
// Ports:
//   clk_i, rst_i         clock, asynchronous active-high reset
//   issue_i/_addr_i      speculative read accepted by memory this cycle, and its address
//   adopt_i              demand read takes over the in-flight word (bridge waits on it itself)
//   consume_i            demand read served from the buffered word this cycle
//   wr_accept_i/_addr_i  write accepted by memory this cycle, and its address
//   req_addr_i           address of the pending demand read
//   mem_rdata_i          memory read data
//   pf_pending_o         speculative read in flight
//   pf_cnt_o             cycles left until the in-flight word arrives (1 = arrives this cycle)
//   pf_data_o            buffered word
//   hit_o                buffered word valid and matches req_addr_i
//   match_pending_o      in-flight (non-stale) word matches req_addr_i
module genie_mem_prefetch_buf
  import genie_mem_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned READ_LAT = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              issue_i,
  input  logic [ADDR_W-1:0] issue_addr_i,
  input  logic              adopt_i,
  input  logic              consume_i,
  input  logic              wr_accept_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              pf_pending_o,
  output logic [CNT_W-1:0]  pf_cnt_o,
  output logic [DATA_W-1:0] pf_data_o,
  output logic              hit_o,
  output logic              match_pending_o
);

  localparam logic [CNT_W-1:0] LatInit = CNT_W'(READ_LAT);

  logic [ADDR_W-1:0] pf_addr_q;
  logic [DATA_W-1:0] pf_data_q;
  logic [CNT_W-1:0]  pf_cnt_q;
  logic              pf_valid_q, pf_pending_q, pf_stale_q;
  logic              wr_hit;

  assign wr_hit          = wr_accept_i && (wr_addr_i == pf_addr_q);
  assign hit_o           = pf_valid_q && (req_addr_i == pf_addr_q);
  assign match_pending_o = pf_pending_q && !pf_stale_q && (req_addr_i == pf_addr_q);
  assign pf_pending_o    = pf_pending_q;
  assign pf_cnt_o        = pf_cnt_q;
  assign pf_data_o       = pf_data_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pf_addr_q    <= '0;
      pf_data_q    <= '0;
      pf_cnt_q     <= '0;
      pf_valid_q   <= 1'b0;
      pf_pending_q <= 1'b0;
      pf_stale_q   <= 1'b0;
    end else if (issue_i) begin
      pf_addr_q    <= issue_addr_i;
      pf_cnt_q     <= LatInit;
      pf_pending_q <= 1'b1;
      pf_stale_q   <= 1'b0;
      pf_valid_q   <= 1'b0;
    end else begin
      if (adopt_i) begin
        pf_pending_q <= 1'b0;
      end else if (pf_pending_q) begin
        if (pf_cnt_q == CNT_W'(1)) begin
          pf_pending_q <= 1'b0;
          pf_data_q    <= mem_rdata_i;
          pf_valid_q   <= !pf_stale_q;
        end else begin
          pf_cnt_q <= pf_cnt_q - CNT_W'(1);
        end
      end
      if (consume_i || wr_hit) pf_valid_q <= 1'b0;
      // A write to the in-flight address makes the returning word obsolete.
      if (wr_hit && pf_pending_q) pf_stale_q <= 1'b1;
    end
  end

endmodule

// File: rtl/genie_mem_bridge.sv
// genie_mem_bridge: converts the accelerator's held-request / pulse-response memory port into
// commands for a pipelined single-port memory with fixed read latency READ_LAT (1..15).
// Writes win over reads; memory back-pressure (mem_stall) holds the command stable.
// Optional sequential-read prefetch is built when GENIE_MEM_PREFETCH_EN is defined.
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   wvalid/waddr/wdata, wready   write request (held) and one-cycle commit pulse
//   rvalid/raddr, rready/rdata   read request (held) and one-cycle data pulse
//   mem_en/mem_we/mem_addr/mem_wdata   memory command (registered)
//   mem_stall                    memory refuses the command this cycle
//   mem_rdata                    memory read data, READ_LAT cycles after an accepted read
module genie_mem_bridge
  import genie_mem_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned READ_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wvalid,
  output logic              wready,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              rvalid,
  output logic              rready,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_stall,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [CNT_W-1:0] LatInit = CNT_W'(READ_LAT);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;

`ifdef GENIE_MEM_PREFETCH_EN
  logic              pf_pending, pf_hit, pf_match;
  logic              pf_issue, pf_adopt, pf_consume, wr_accept;
  logic [CNT_W-1:0]  pf_cnt;
  logic [DATA_W-1:0] pf_data;

  always_comb begin
    wr_accept  = (state_q == StWrIssue) && !mem_stall;
    // mem_en in RD_RESP is only ever the speculative read of the next word.
    pf_issue   = (state_q == StRdResp) && mem_en && !mem_stall;
    // Adopting with one cycle left would miss the word; let it land in the buffer instead.
    pf_adopt   = (state_q == StIdle) && pf_pending && !wvalid && rvalid && pf_match &&
                 (pf_cnt > CNT_W'(1));
    pf_consume = (state_q == StIdle) && !pf_pending && !wvalid && rvalid && pf_hit;
  end

  genie_mem_prefetch_buf #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .READ_LAT(READ_LAT)
  ) u_prefetch_buf (
    .clk_i          (clk),
    .rst_i          (rst),
    .issue_i        (pf_issue),
    .issue_addr_i   (mem_addr),
    .adopt_i        (pf_adopt),
    .consume_i      (pf_consume),
    .wr_accept_i    (wr_accept),
    .wr_addr_i      (mem_addr),
    .req_addr_i     (raddr),
    .mem_rdata_i    (mem_rdata),
    .pf_pending_o   (pf_pending),
    .pf_cnt_o       (pf_cnt),
    .pf_data_o      (pf_data),
    .hit_o          (pf_hit),
    .match_pending_o(pf_match)
  );
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      wready    <= 1'b0;
      rready    <= 1'b0;
      rdata     <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
`ifdef GENIE_MEM_PREFETCH_EN
          if (pf_adopt) begin
            // Wait on the in-flight speculative word as if it were our own demand read.
            mem_addr <= raddr;
            cnt_q    <= pf_cnt - CNT_W'(1);
            state_q  <= StRdWait;
          end else if (pf_consume) begin
            rdata    <= pf_data;
            rready   <= 1'b1;
            mem_en   <= (raddr != '1);
            mem_we   <= 1'b0;
            mem_addr <= raddr + ADDR_W'(1);
            state_q  <= StRdResp;
          end else if (pf_pending) begin
            // Anything else waits until the speculative read drains.
          end else
`endif
          if (wvalid) begin
            mem_en    <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= waddr;
            mem_wdata <= wdata;
            state_q   <= StWrIssue;
          end else if (rvalid) begin
            mem_en   <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= raddr;
            state_q  <= StRdIssue;
          end
        end
        StWrIssue: begin
          if (!mem_stall) begin
            mem_en  <= 1'b0;
            mem_we  <= 1'b0;
            wready  <= 1'b1;
            state_q <= StWrAck;
          end
        end
        StWrAck: begin
          wready  <= 1'b0;
          state_q <= StIdle;
        end
        StRdIssue: begin
          if (!mem_stall) begin
            mem_en  <= 1'b0;
            cnt_q   <= LatInit;
            state_q <= StRdWait;
          end
        end
        StRdWait: begin
          // Data is on mem_rdata in the cycle the counter would decrement to zero.
          if (cnt_q == CNT_W'(1)) begin
            cnt_q   <= '0;
            rdata   <= mem_rdata;
            rready  <= 1'b1;
            state_q <= StRdResp;
`ifdef GENIE_MEM_PREFETCH_EN
            mem_en   <= (mem_addr != '1);
            mem_we   <= 1'b0;
            mem_addr <= mem_addr + ADDR_W'(1);
`endif
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        StRdResp: begin
          rready  <= 1'b0;
          mem_en  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_genie_mem_bridge.sv
module tb_genie_mem_bridge;

  localparam int unsigned ADDR_W   = 26;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned READ_LAT = 2;
  localparam int unsigned GAP      = READ_LAT + 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              wvalid = 1'b0, rvalid = 1'b0, mem_stall = 1'b0;
  logic [ADDR_W-1:0] waddr = '0, raddr = '0;
  logic [DATA_W-1:0] wdata = '0;
  logic              wready, rready, mem_en, mem_we;
  logic [DATA_W-1:0] rdata, mem_wdata, mem_rdata;
  logic [ADDR_W-1:0] mem_addr;

  always #5 clk = ~clk;

  genie_mem_bridge #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .READ_LAT(READ_LAT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wvalid   (wvalid),
    .wready   (wready),
    .waddr    (waddr),
    .wdata    (wdata),
    .rvalid   (rvalid),
    .rready   (rready),
    .raddr    (raddr),
    .rdata    (rdata),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_stall(mem_stall),
    .mem_rdata(mem_rdata)
  );

  // Unwritten words read back as a fixed address-derived pattern.
  function automatic logic [DATA_W-1:0] init_word(input logic [ADDR_W-1:0] a);
    return 32'h5A00_0000 ^ DATA_W'(a);
  endfunction

  // ---------------- memory device: 1024 words, fixed-latency read pipe ----------------
  logic [DATA_W-1:0] dev_data [1024];
  bit                dev_wr   [1024];
  logic [DATA_W-1:0] pipe_d   [READ_LAT];
  bit                pipe_v   [READ_LAT];
  int                n_rd = 0, n_wr = 0, n_wready = 0, n_rready = 0, n_unstable = 0;
  bit                stall_seen = 1'b0;
  logic              st_we;
  logic [ADDR_W-1:0] st_addr;
  logic [DATA_W-1:0] st_wdata;

  function automatic logic [DATA_W-1:0] dev_read(input logic [ADDR_W-1:0] a);
    return dev_wr[a[9:0]] ? dev_data[a[9:0]] : init_word(a);
  endfunction

  always @(posedge clk) begin
    if (mem_en && !mem_stall && mem_we) begin
      dev_data[mem_addr[9:0]] <= mem_wdata;
      dev_wr[mem_addr[9:0]]   <= 1'b1;
      n_wr <= n_wr + 1;
    end
    if (mem_en && !mem_stall && !mem_we) n_rd <= n_rd + 1;
    pipe_v[0] <= mem_en && !mem_we && !mem_stall;
    pipe_d[0] <= dev_read(mem_addr);
    for (int i = 1; i < READ_LAT; i++) begin
      pipe_v[i] <= pipe_v[i-1];
      pipe_d[i] <= pipe_d[i-1];
    end
    // A refused command must be presented unchanged in the next cycle.
    if (stall_seen && !(mem_en && mem_we == st_we && mem_addr == st_addr &&
                        mem_wdata == st_wdata))
      n_unstable <= n_unstable + 1;
    stall_seen <= mem_en && mem_stall;
    st_we      <= mem_we;
    st_addr    <= mem_addr;
    st_wdata   <= mem_wdata;
    if (wready === 1'b1) n_wready <= n_wready + 1;
    if (rready === 1'b1) n_rready <= n_rready + 1;
  end

  assign mem_rdata = pipe_v[READ_LAT-1] ? pipe_d[READ_LAT-1] : 32'hBAD0_BAD0;

  // ---------------- reference: what each address should hold ----------------
  logic [DATA_W-1:0] ref_mem [logic [ADDR_W-1:0]];

  function automatic logic [DATA_W-1:0] ref_read(input logic [ADDR_W-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  int n_chk = 0, n_pass = 0, n_fail = 0;
  int exp_wpulse = 0, exp_rpulse = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Raise the requested write and/or read at cycle 0, stall the first `stalls` command cycles,
  // and return the cycle index at which each response pulse was seen (-1 if never).
  task automatic run_req(input bit dw, input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                         input bit dr, input logic [ADDR_W-1:0] ra, input int stalls,
                         output int wlat, output int rlat, output logic [DATA_W-1:0] rd);
    int cyc = 0;
    int stall_left = stalls;
    wlat = -1;
    rlat = -1;
    rd   = '0;
    @(negedge clk);
    wvalid = dw; waddr = wa; wdata = wd;
    rvalid = dr; raddr = ra;
    while (((dw && wlat < 0) || (dr && rlat < 0)) && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (wready && wlat < 0) begin wlat = cyc; wvalid = 1'b0; end
      if (rready && rlat < 0) begin rlat = cyc; rd = rdata; rvalid = 1'b0; end
      mem_stall = (stall_left > 0) && mem_en;
      if (mem_stall) stall_left--;
    end
    mem_stall = 1'b0; wvalid = 1'b0; rvalid = 1'b0;
    if (dw) begin ref_mem[wa] = wd; exp_wpulse++; end
    if (dr) exp_rpulse++;
  endtask

  initial begin
    automatic int wl, rl, base;
    automatic int base_rd, base_rr;
    automatic logic [DATA_W-1:0] rd, expd, wd;
    automatic logic [ADDR_W-1:0] wa, ra;
    automatic logic [ADDR_W-1:0] pool [8] = '{26'h200, 26'h201, 26'h202, 26'h203,
                                               26'h204, 26'h205, 26'h3FF_FFFF, 26'h206};

    repeat (3) @(negedge clk);
    check("reset_ctrl", {wready, rready, mem_en, mem_we}, 4'b0);
    check("reset_rdata", rdata, 0);
    check("reset_mem_addr", mem_addr, 0);
    check("reset_mem_wdata", mem_wdata, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Preload 0x100, then a plain read of it.
    run_req(1'b1, 26'h100, 32'hDEAD_BEEF, 1'b0, '0, 0, wl, rl, rd);
    check("wr_lat", wl, 2);
    repeat (GAP) @(negedge clk);
    base = n_rd;
    run_req(1'b0, '0, '0, 1'b1, 26'h100, 0, wl, rl, rd);
    check("rd_lat", rl, READ_LAT + 2);
    check("rd_data", rd, 32'hDEAD_BEEF);
    check("rd_one_cmd", n_rd - base, 1);

    // Simultaneous write and read: write first.
    repeat (GAP) @(negedge clk);
    expd = ref_read(26'h40);
    run_req(1'b1, 26'h20, 32'h1234, 1'b1, 26'h40, 0, wl, rl, rd);
    check("both_wlat", wl, 2);
    check("both_rlat", rl, 7);
    check("both_rdata", rd, expd);
    check("both_dev_word", dev_read(26'h20), 32'h1234);

    // Three stalled cycles while the read command is presented.
    repeat (GAP) @(negedge clk);
    base = n_rd;
    run_req(1'b0, '0, '0, 1'b1, 26'h300, 3, wl, rl, rd);
    check("stall_rlat", rl, 7);
    check("stall_rdata", rd, ref_read(26'h300));
    check("stall_one_cmd", n_rd - base, 1);
    check("stall_stable", n_unstable, 0);

    // Asynchronous reset while the read is waiting for data.
    repeat (GAP) @(negedge clk);
    @(negedge clk);
    rvalid = 1'b1; raddr = 26'h8;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_async_ctrl", {wready, rready, mem_en, mem_we}, 4'b0);
    check("rst_async_rdata", rdata, 0);
    check("rst_async_mem_addr", mem_addr, 0);
    check("rst_async_mem_wdata", mem_wdata, 0);
    rvalid = 1'b0;
    base_rr = n_rready;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    base_rd = n_rd;
    repeat (8) @(negedge clk);
    check("rst_no_rready", n_rready - base_rr, 0);
    check("rst_no_cmd", n_rd - base_rd, 0);
    run_req(1'b0, '0, '0, 1'b1, 26'h8, 0, wl, rl, rd);
    check("post_rst_rlat", rl, READ_LAT + 2);
    check("post_rst_rdata", rd, ref_read(26'h8));

`ifdef GENIE_MEM_PREFETCH_EN
    // Sequential read served from the prefetched word.
    repeat (GAP) @(negedge clk);
    run_req(1'b0, '0, '0, 1'b1, 26'h10, 0, wl, rl, rd);
    check("pf_first_rdata", rd, ref_read(26'h10));
    repeat (GAP) @(negedge clk);
    base = n_rd;
    run_req(1'b0, '0, '0, 1'b1, 26'h11, 0, wl, rl, rd);
    check("pf_hit_rlat", rl, 1);
    check("pf_hit_rdata", rd, ref_read(26'h11));
    check("pf_hit_no_cmd", n_rd - base, 0);
    // Write to the prefetched address forces a real read.
    repeat (GAP) @(negedge clk);
    run_req(1'b0, '0, '0, 1'b1, 26'h10, 0, wl, rl, rd);
    repeat (GAP) @(negedge clk);
    run_req(1'b1, 26'h11, 32'hAA, 1'b0, '0, 0, wl, rl, rd);
    repeat (GAP) @(negedge clk);
    run_req(1'b0, '0, '0, 1'b1, 26'h11, 0, wl, rl, rd);
    check("pf_inval_rlat", rl, READ_LAT + 2);
    check("pf_inval_rdata", rd, 32'hAA);
`endif

    // Randomised traffic against the reference contents and latency rules.
    for (int i = 0; i < 30; i++) begin
      automatic int kind = int'($urandom_range(0, 2));
      automatic int st   = int'($urandom_range(0, 3));
      automatic bit dw   = (kind != 1);
      automatic bit dr   = (kind != 0);
      wa = pool[$urandom_range(0, 7)];
      ra = pool[$urandom_range(0, 7)];
      wd = $urandom;
      expd = (dw && wa == ra) ? wd : ref_read(ra);
      repeat (GAP) @(negedge clk);
      run_req(dw, wa, wd, dr, ra, st, wl, rl, rd);
      if (dr) check("rnd_rdata", rd, expd);
`ifndef GENIE_MEM_PREFETCH_EN
      if (dw) check("rnd_wlat", wl, 2 + st);
      if (dr) check("rnd_rlat", rl, dw ? 2 + st + READ_LAT + 3 : READ_LAT + 2 + st);
`endif
    end

    repeat (GAP) @(negedge clk);
    check("wready_pulses", n_wready, exp_wpulse);
    check("rready_pulses", n_rready, exp_rpulse);
    check("stable_total", n_unstable, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/genie_mem_bridge.md
Name: genie_mem_bridge

Overview:
- Sits directly downstream of the accelerator top's shared external-memory port; the layer loaders (FC/CV/MP) are muxed onto that port.
- Converts the port's held-request, strobe-response protocol into commands for a pipelined single-port memory with fixed read latency.
- Arbitrates reads against writes, tolerates memory back-pressure, and optionally prefetches the next sequential read word.

Parameters:
ADDR_W, 26, word-address width (matches waddr/raddr)
DATA_W, 32, data width
READ_LAT, 2, memory read latency in cycles from accepted command to mem_rdata valid; legal range 1..15

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
wvalid  in  1  write request; held with waddr/wdata until wready
wready  out  1  one-cycle pulse: write committed to memory
waddr  in  ADDR_W  write address
wdata  in  DATA_W  write data
rvalid  in  1  read request; held with raddr until rready
rready  out  1  one-cycle pulse: rdata valid, read request consumed
raddr  in  ADDR_W  read address
rdata  out  DATA_W  read data, valid only while rready=1, otherwise held
mem_en  out  1  memory command valid
mem_we  out  1  1 = write, 0 = read
mem_addr  out  ADDR_W  command address
mem_wdata  out  DATA_W  write data
mem_stall  in  1  memory refuses the command this cycle
mem_rdata  in  DATA_W  read data, valid READ_LAT cycles after an accepted read

Behaviour:
- All outputs are registered.
- Reset values: wready=0, rready=0, rdata=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0. FSM returns to IDLE, the latency counter clears, and all prefetch state is invalidated.
- Reset asserted mid-operation discards in-flight reads. A write command issued in the same cycle as reset is not guaranteed to complete.
- FSM states: IDLE, WR_ISSUE, WR_ACK, RD_ISSUE, RD_WAIT, RD_RESP.
- IDLE:
  - wvalid=1 goes to WR_ISSUE; writes have priority when wvalid and rvalid are both high.
  - Otherwise rvalid=1 goes to RD_ISSUE.
  - The request address and data are latched on this transition.
- WR_ISSUE:
  - Drives mem_en=1, mem_we=1 with the latched address and data.
  - Stays in WR_ISSUE while mem_stall=1, holding the command stable.
  - On acceptance (mem_stall=0), goes to WR_ACK.
- WR_ACK: wready=1 for exactly one cycle, then IDLE.
- RD_ISSUE:
  - Drives mem_en=1, mem_we=0.
  - Holds while mem_stall=1.
  - On acceptance, loads the 4-bit latency counter with READ_LAT and goes to RD_WAIT.
- RD_WAIT:
  - The counter decrements each cycle.
  - When it reaches 0, mem_rdata is captured into rdata and the FSM goes to RD_RESP.
- RD_RESP: rready=1 for exactly one cycle, then IDLE.
- Timing, no stall:
  - Read: rvalid sampled high in IDLE at cycle t gives rready at cycle t+READ_LAT+2.
  - Write: wvalid at cycle t gives wready at cycle t+2.
- Each cycle of mem_stall adds one cycle to either latency.
- Requester contract: the requester changes or drops its request on the edge where it samples the response pulse. IDLE therefore samples a fresh request the following cycle, and no duplicate command is issued.
- mem_en is high only in WR_ISSUE and RD_ISSUE, plus the prefetch slot when the option is enabled.
- At most one demand read is outstanding.

Optional Feature:
Macro: GENIE_MEM_PREFETCH_EN
- With the macro:
  - In RD_RESP for address A, with A != 2^ADDR_W-1, the bridge issues a read of A+1 in the same cycle.
  - If mem_stall=1 in that cycle, the prefetch is dropped.
  - The prefetched data is captured into pf_data after READ_LAT cycles and pf_valid is set.
  - IDLE with rvalid=1 and raddr==pf_addr and pf_valid=1: go directly to RD_RESP with rdata=pf_data (latency 1 cycle). pf_valid clears and the chain continues.
  - raddr==pf_addr while the prefetch is still in flight: wait in RD_WAIT for that data.
  - Non-matching read or any write while a prefetch is in flight: wait until the prefetch drains before issuing.
  - Any accepted write with waddr==pf_addr clears pf_valid, or marks the in-flight prefetch stale so its data is discarded.
- Without the macro: no speculative commands are issued and the prefetch registers do not exist.

Decomposition:
- Package genie_mem_pkg: FSM state encoding, ADDR_W/DATA_W defaults, latency-counter width constant.
- One sub-module: genie_mem_prefetch_buf. It holds pf_addr/pf_data/pf_valid/pf_pending/pf_stale and owns the hit and invalidate compare logic. It is instantiated only under GENIE_MEM_PREFETCH_EN.

Test Plan:
- READ_LAT=2: rvalid=1, raddr=0x100 at cycle 0; memory returns 0xDEADBEEF -> rready=1 at cycle 4 with rdata=0xDEADBEEF, exactly one mem_en read.
- wvalid (waddr=0x20, wdata=0x1234) and rvalid (raddr=0x40) both raised at cycle 0 -> write command issued first, wready at cycle 2; read issued afterwards, rready at cycle 7.
- mem_stall held high 3 cycles during RD_ISSUE -> mem_en/mem_addr held stable; rready delayed to cycle 7.
- Reset asserted in RD_WAIT -> all outputs 0 immediately; no rready after release; next read of 0x8 completes normally.
- GENIE_MEM_PREFETCH_EN: read 0x10, then read 0x11 after the prefetch lands -> second rready 1 cycle after rvalid, data = mem[0x11].
- GENIE_MEM_PREFETCH_EN: read 0x10, write 0x11=0xAA, read 0x11 -> no prefetch hit; demand read issued and returns 0xAA.
